// File: rtl/nts_keymem_pkg.sv
// nts_keymem shared definitions: register map, identity constants,
// key geometry and client FSM state encoding.
package nts_keymem_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_WORDS = 16;
    localparam int MEM_WORDS = NUM_KEYS * KEY_WORDS;

    localparam logic [7:0] ADDR_NAME0    = 8'h00;
    localparam logic [7:0] ADDR_NAME1    = 8'h01;
    localparam logic [7:0] ADDR_VERSION  = 8'h02;
    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h09;
    localparam logic [7:0] ADDR_KEY_ID   = 8'h10;
    localparam logic [7:0] ADDR_KEY_CFG  = 8'h20;

    localparam logic [31:0] CORE_NAME0   = 32'h6b65796d;
    localparam logic [31:0] CORE_NAME1   = 32'h656d2020;
    localparam logic [31:0] CORE_VERSION = 32'h00000001;

    typedef struct packed {
        logic length;
        logic valid;
    } key_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/nts_keymem_lookup.sv
// Key ID comparator with lowest-index priority over the key slots.
// Only slots marked valid can match.
module nts_keymem_lookup
    import nts_keymem_pkg::*;
(
    input  logic [NUM_KEYS-1:0][31:0] ids,
    input  logic [NUM_KEYS-1:0]       valid,
    input  logic [31:0]               search_id,
    output logic                      hit,
    output logic [1:0]                idx
);

    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        // Descending scan so the lowest matching index is written last.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (valid[i] && ids[i] == search_id) begin
                hit = 1'b1;
                idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/nts_keymem.sv
// Server key memory: host register API plus a client port that selects
// a key (current or by ID) and streams its words out.
module nts_keymem
    import nts_keymem_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        get_current_key,
    input  logic        get_key_with_id,
    input  logic [31:0] server_key_id,
    input  logic [3:0]  key_word,
    output logic        key_valid,
    output logic        key_length,
    output logic [31:0] key_id,
    output logic [31:0] key_data,
    output logic        ready
);

    state_t                    state_q, state_d;
    logic [1:0]                ctrl_q, ctrl_d;
    logic [NUM_KEYS-1:0][31:0] kid_q, kid_d;
    key_cfg_t [NUM_KEYS-1:0]   cfg_q, cfg_d;
    logic [31:0]               mem_q [MEM_WORDS];
    logic [31:0]               mem_d [MEM_WORDS];

    logic        req_cur_q, req_cur_d;
    logic [31:0] srch_q, srch_d;
    logic [1:0]  sel_q, sel_d;
    logic        act_q, act_d;
    logic        valid_q, valid_d;
    logic        len_q, len_d;
    logic [31:0] id_q, id_d;
    logic [31:0] data_q, data_d;

    logic [NUM_KEYS-1:0] key_ok;
    logic                hit;
    logic [1:0]          hit_idx;
    logic                wr;
    logic [31:0]         rd;

    assign wr    = cs & we;
    assign ready = (state_q == ST_IDLE);

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_ok[i] = cfg_q[i].valid;
        end
    end

    nts_keymem_lookup u_lookup (
        .ids       (kid_q),
        .valid     (key_ok),
        .search_id (srch_q),
        .hit       (hit),
        .idx       (hit_idx)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        kid_d  = kid_q;
        cfg_d  = cfg_q;
        mem_d  = mem_q;
        if (wr) begin
            unique case (1'b1)
                address == ADDR_CTRL:
                    ctrl_d = write_data[1:0];
                address[7:2] == ADDR_KEY_ID[7:2]:
                    kid_d[address[1:0]] = write_data;
                address[7:2] == ADDR_KEY_CFG[7:2]:
                    cfg_d[address[1:0]] = write_data[1:0];
                address[7:6] == 2'b01:
                    mem_d[address[5:0]] = write_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        if (cs && !we) begin
            unique case (1'b1)
                address == ADDR_NAME0:   rd = CORE_NAME0;
                address == ADDR_NAME1:   rd = CORE_NAME1;
                address == ADDR_VERSION: rd = CORE_VERSION;
                address == ADDR_CTRL:    rd = {30'b0, ctrl_q};
                address == ADDR_STATUS:  rd = {31'b0, ready};
                address[7:2] == ADDR_KEY_ID[7:2]:
                    rd = kid_q[address[1:0]];
                address[7:2] == ADDR_KEY_CFG[7:2]:
                    rd = {30'b0, cfg_q[address[1:0]]};
                address[7:6] == 2'b01:
                    rd = mem_q[address[5:0]];
                default: rd = '0;
            endcase
        end
    end

    assign read_data = rd;

    always_comb begin
        state_d   = state_q;
        req_cur_d = req_cur_q;
        srch_d    = srch_q;
        sel_d     = sel_q;
        act_d     = act_q;
        unique case (state_q)
            ST_IDLE: begin
                if (get_current_key || get_key_with_id) begin
                    state_d   = ST_LOOKUP;
                    req_cur_d = get_current_key;
                    srch_d    = server_key_id;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_DONE;
                if (req_cur_q) begin
                    sel_d = ctrl_q;
                    act_d = 1'b1;
                end else if (hit) begin
                    sel_d = hit_idx;
                    act_d = 1'b1;
                end else begin
                    act_d = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs track the selected slot so host edits show up promptly.
    always_comb begin
        valid_d = act_d & cfg_q[sel_d].valid;
        len_d   = act_d & cfg_q[sel_d].length;
        id_d    = act_d ? kid_q[sel_d] : 32'h0;
        data_d  = mem_q[{sel_q, key_word}];
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            kid_q     <= '0;
            cfg_q     <= '0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            req_cur_q <= 1'b0;
            srch_q    <= '0;
            sel_q     <= '0;
            act_q     <= 1'b0;
            valid_q   <= 1'b0;
            len_q     <= 1'b0;
            id_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            kid_q     <= kid_d;
            cfg_q     <= cfg_d;
            mem_q     <= mem_d;
            req_cur_q <= req_cur_d;
            srch_q    <= srch_d;
            sel_q     <= sel_d;
            act_q     <= act_d;
            valid_q   <= valid_d;
            len_q     <= len_d;
            id_q      <= id_d;
            data_q    <= data_d;
        end
    end

    assign key_valid  = valid_q;
    assign key_length = len_q;
    assign key_id     = id_q;
    assign key_data   = data_q;

endmodule

// File: tb/tb_nts_keymem.sv
// Self-checking bench for nts_keymem: directed table, corner sequences
// and random traffic against an array-based register/lookup model.
module tb_nts_keymem;

    logic        clk = 1'b0;
    logic        areset;
    logic        cs, we;
    logic [7:0]  address;
    logic [31:0] write_data, read_data;
    logic        get_current_key, get_key_with_id;
    logic [31:0] server_key_id;
    logic [3:0]  key_word;
    logic        key_valid, key_length, ready;
    logic [31:0] key_id, key_data;

    always #5 clk = ~clk;

    nts_keymem dut (
        .clk             (clk),
        .areset          (areset),
        .cs              (cs),
        .we              (we),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .get_current_key (get_current_key),
        .get_key_with_id (get_key_with_id),
        .server_key_id   (server_key_id),
        .key_word        (key_word),
        .key_valid       (key_valid),
        .key_length      (key_length),
        .key_id          (key_id),
        .key_data        (key_data),
        .ready           (ready)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model state
    logic [31:0] m_id  [4];
    logic        m_val [4];
    logic        m_len [4];
    logic [31:0] m_mem [4][16];
    logic [1:0]  m_ctrl;
    int          m_sel;
    bit          m_act;

    typedef struct {
        bit          cur;
        bit          byid;
        logic [31:0] sid;
        bit          ev;
        bit          el;
        logic [31:0] eid;
    } vec_t;

    vec_t vt [6];

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_id[i] = 0; m_val[i] = 0; m_len[i] = 0;
            for (int w = 0; w < 16; w++) m_mem[i][w] = 0;
        end
        m_ctrl = 0; m_sel = 0; m_act = 0;
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [31:0] d);
        int ai = int'(a);
        if (ai == 8) m_ctrl = d[1:0];
        else if (ai >= 16 && ai < 20) m_id[ai-16] = d;
        else if (ai >= 32 && ai < 36) begin
            m_val[ai-32] = d[0];
            m_len[ai-32] = d[1];
        end else if (ai >= 64 && ai < 128) m_mem[(ai-64)/16][(ai-64)%16] = d;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int ai = int'(a);
        if (ai == 0) return 32'h6b65796d;
        if (ai == 1) return 32'h656d2020;
        if (ai == 2) return 32'h1;
        if (ai == 8) return {30'b0, m_ctrl};
        if (ai == 9) return 32'h1;
        if (ai >= 16 && ai < 20) return m_id[ai-16];
        if (ai >= 32 && ai < 36) return {30'b0, m_len[ai-32], m_val[ai-32]};
        if (ai >= 64 && ai < 128) return m_mem[(ai-64)/16][(ai-64)%16];
        return 0;
    endfunction

    function automatic void m_request(input bit cur, input bit byid,
                                      input logic [31:0] sid);
        if (cur) begin
            m_sel = int'(m_ctrl);
            m_act = 1;
        end else if (byid) begin
            int found = -1;
            for (int i = 0; i < 4; i++)
                if (found < 0 && m_val[i] && m_id[i] == sid) found = i;
            if (found >= 0) begin
                m_sel = found;
                m_act = 1;
            end else begin
                m_act = 0;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    task automatic api_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1; we = 1; address = a; write_data = d;
        @(negedge clk);
        cs = 0; we = 0;
        m_write(a, d);
    endtask

    task automatic api_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1; we = 0; address = a;
        #1 d = read_data;
        cs = 0;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_valid"}, {31'b0, key_valid}, {31'b0, m_act & m_val[m_sel]});
        chk({nm, "_len"}, {31'b0, key_length}, {31'b0, m_act & m_len[m_sel]});
        chk({nm, "_id"}, key_id, m_act ? m_id[m_sel] : 32'h0);
    endtask

    // Leaves the bench at the T+2 sampling point with the model updated.
    task automatic req_start(input bit cur, input bit byid, input logic [31:0] sid);
        @(negedge clk);
        get_current_key = cur; get_key_with_id = byid; server_key_id = sid;
        @(negedge clk);
        get_current_key = 0; get_key_with_id = 0;
        chk("rdy_t1", {31'b0, ready}, 0);
        @(negedge clk);
        chk("rdy_t2", {31'b0, ready}, 0);
        m_request(cur, byid, sid);
    endtask

    task automatic req_end();
        @(negedge clk);
        chk("rdy_t3", {31'b0, ready}, 1);
    endtask

    function automatic logic [31:0] pick_id();
        case ($urandom_range(0, 4))
            0: return 32'h11;
            1: return 32'h22;
            2: return 32'h33;
            3: return 32'h44;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] rv;

    initial begin
        areset = 1; cs = 0; we = 0; address = 0; write_data = 0;
        get_current_key = 0; get_key_with_id = 0; server_key_id = 0;
        key_word = 0;
        m_reset();
        repeat (2) @(negedge clk);
        areset = 0;

        // Reset state and identity registers
        chk("rst_ready", {31'b0, ready}, 1);
        chk("rst_valid", {31'b0, key_valid}, 0);
        chk("rst_len", {31'b0, key_length}, 0);
        chk("rst_id", key_id, 0);
        chk("rst_data", key_data, 0);
        api_rd(8'h00, rv); chk("name0", rv, 32'h6b65796d);
        api_rd(8'h01, rv); chk("name1", rv, 32'h656d2020);
        api_rd(8'h02, rv); chk("version", rv, 32'h00000001);
        api_rd(8'h09, rv); chk("status", rv, 32'h1);
        api_rd(8'h30, rv); chk("unmapped", rv, 32'h0);
        api_wr(8'h09, 32'hffff_ffff);
        api_wr(8'h00, 32'h0);
        api_rd(8'h00, rv); chk("name0_ro", rv, 32'h6b65796d);

        // Key 2 as current key, streamed out word by word
        api_wr(8'h12, 32'hCAFE0002);
        api_wr(8'h22, 32'h3);
        for (int w = 0; w < 16; w++) api_wr(8'(8'h60 + w), 32'h1000 + w);
        api_wr(8'h08, 32'h2);
        req_start(1, 0, 0);
        chk("k2_valid", {31'b0, key_valid}, 1);
        chk("k2_len", {31'b0, key_length}, 1);
        chk("k2_id", key_id, 32'hCAFE0002);
        req_end();
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            key_word = 4'(w);
            @(negedge clk);
            chk($sformatf("k2_word%0d", w), key_data, 32'h1000 + w);
        end

        // Remaining slots; key 3 duplicates key 0's ID
        api_wr(8'h10, 32'h11); api_wr(8'h20, 32'h1);
        api_wr(8'h11, 32'h22); api_wr(8'h21, 32'h3);
        api_wr(8'h13, 32'h11); api_wr(8'h23, 32'h3);

        vt[0] = '{1, 0, 32'h0,        1, 1, 32'hCAFE0002};
        vt[1] = '{0, 1, 32'h22,       1, 1, 32'h22};
        vt[2] = '{0, 1, 32'h33,       0, 0, 32'h0};
        vt[3] = '{0, 1, 32'h11,       1, 0, 32'h11};
        vt[4] = '{1, 1, 32'h22,       1, 1, 32'hCAFE0002};
        vt[5] = '{0, 1, 32'hCAFE0002, 1, 1, 32'hCAFE0002};
        for (int i = 0; i < 6; i++) begin
            req_start(vt[i].cur, vt[i].byid, vt[i].sid);
            chk($sformatf("vec%0d_valid", i), {31'b0, key_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d_len", i), {31'b0, key_length}, {31'b0, vt[i].el});
            chk($sformatf("vec%0d_id", i), key_id, vt[i].eid);
            req_end();
        end

        // Invalidated key no longer matches
        api_wr(8'h21, 32'h2);
        req_start(0, 1, 32'h22);
        chk("inval_valid", {31'b0, key_valid}, 0);
        chk("inval_id", key_id, 0);
        req_end();

        // Both requests with ctrl=0: current key wins
        api_wr(8'h08, 32'h0);
        req_start(1, 1, 32'h22);
        chk("both_id", key_id, 32'h11);
        chk("both_valid", {31'b0, key_valid}, 1);
        req_end();

        // Request while busy is ignored
        @(negedge clk);
        get_key_with_id = 1; server_key_id = 32'hCAFE0002;
        @(negedge clk);
        get_key_with_id = 0; get_current_key = 1;
        chk("busy_t1", {31'b0, ready}, 0);
        @(negedge clk);
        get_current_key = 0;
        chk("busy_t2", {31'b0, ready}, 0);
        m_request(0, 1, 32'hCAFE0002);
        chk("busy_id", key_id, 32'hCAFE0002);
        for (int k = 3; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("busy_t%0d", k), {31'b0, ready}, 1);
        end

        // Host write to the selected key reaches the outputs
        api_wr(8'h22, 32'h1);
        @(negedge clk);
        chk_model("live_cfg");
        api_wr(8'h61, 32'hABCD0001);
        @(negedge clk); key_word = 4'd1;
        @(negedge clk);
        chk("live_data", key_data, 32'hABCD0001);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            int op = $urandom_range(0, 8);
            if (op <= 3) begin
                logic [7:0] a;
                logic [31:0] d = $urandom;
                case ($urandom_range(0, 4))
                    0: a = 8'h08;
                    1: begin a = 8'(8'h10 + $urandom_range(0, 3)); d = pick_id(); end
                    2: a = 8'(8'h20 + $urandom_range(0, 3));
                    3: a = 8'(8'h40 + $urandom_range(0, 63));
                    default: a = 8'($urandom);
                endcase
                api_wr(a, d);
            end else if (op == 4) begin
                logic [7:0] a = 8'($urandom);
                api_rd(a, rv);
                chk($sformatf("rnd_rd_%02h", a), rv, m_read(a));
            end else if (op <= 6) begin
                bit c = 1'($urandom);
                bit b = 1'($urandom);
                if (!c && !b) b = 1;
                req_start(c, b, pick_id());
                chk_model("rnd_req");
                req_end();
            end else if (op == 7) begin
                int w = $urandom_range(0, 15);
                @(negedge clk); key_word = 4'(w);
                @(negedge clk);
                chk("rnd_data", key_data, m_mem[m_sel][w]);
            end else begin
                @(negedge clk);
                chk_model("rnd_out");
            end
        end

        // Reset during a lookup
        @(negedge clk);
        get_current_key = 1;
        @(negedge clk);
        get_current_key = 0;
        chk("mid_t1", {31'b0, ready}, 0);
        areset = 1;
        @(negedge clk);
        areset = 0;
        m_reset();
        chk("mid_ready", {31'b0, ready}, 1);
        chk("mid_valid", {31'b0, key_valid}, 0);
        chk("mid_len", {31'b0, key_length}, 0);
        chk("mid_id", key_id, 0);
        @(negedge clk);
        chk("mid_data", key_data, 0);
        for (int a = 8; a < 128; a++) begin
            if (a == 8 || (a >= 16 && a < 20) || (a >= 32 && a < 36) || a >= 64) begin
                api_rd(8'(a), rv);
                chk($sformatf("mid_reg_%02h", a), rv, 32'h0);
            end
        end
        @(negedge clk);
        chk("mid_idle", {31'b0, ready}, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
